// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM state and the latched downstream request.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DROP_I  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
        logic        rd;
        logic        wr;
    } arb_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: muxes fetch and LSQ word ports onto one memory port; grant 1 cycle after request,
// response passed through combinationally, one IDLE bubble per transaction; requesters hold level until resp.
// Build option MEM_ARB_RR_EN: strict round-robin replaces data priority plus fetch starvation counter.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_ip,
    input  logic        instr_read,
    input  logic [31:0] instr_mem_address,
    output logic        instr_mem_resp,
    output logic [31:0] instr_mem_rdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mbe,
    input  logic [31:0] data_mem_address,
    input  logic [31:0] data_mem_wdata,
    output logic        data_mem_resp,
    output logic [31:0] data_mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_mbe,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);

    arb_state_t state_q, state_d;
    arb_req_t   req_q, req_d;
    logic       data_req;
    logic       data_win;

`ifdef MEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;
`else
    localparam int unsigned    CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    logic [CNT_W-1:0] starve_q, starve_d;
`endif

    assign data_req = data_read | data_write;

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        instr_mem_resp  = 1'b0;
        instr_mem_rdata = '0;
        data_mem_resp   = 1'b0;
        data_mem_rdata  = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_mbe         = '0;
        mem_address     = '0;
        mem_wdata       = '0;
`ifdef MEM_ARB_RR_EN
        last_grant_d    = last_grant_q;
        data_win        = data_req && (!instr_read || !last_grant_q);
`else
        starve_d        = starve_q;
        data_win        = data_req && (!instr_read || (starve_q < STARVE_MAX));
`endif

        unique case (state_q)
            IDLE: begin
`ifndef MEM_ARB_RR_EN
                // Counts only data wins that left a fetch waiting; anything else restarts the count.
                if (!instr_read || !data_win) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_MAX) begin
                    starve_d = starve_q + 1'b1;
                end
`endif
                if (data_win) begin
                    state_d     = SERVE_D;
                    req_d.addr  = data_mem_address;
                    req_d.wdata = data_mem_wdata;
                    req_d.mbe   = data_mbe;
                    req_d.rd    = data_read & ~data_write;
                    req_d.wr    = data_write;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = 1'b1;
`endif
                end else if (instr_read) begin
                    state_d     = SERVE_I;
                    req_d.addr  = instr_mem_address;
                    req_d.wdata = '0;
                    req_d.mbe   = 4'hF;
                    req_d.rd    = 1'b1;
                    req_d.wr    = 1'b0;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            SERVE_D: begin
                mem_read    = req_q.rd;
                mem_write   = req_q.wr;
                mem_mbe     = req_q.mbe;
                mem_address = req_q.addr;
                mem_wdata   = req_q.wdata;
                if (mem_resp) begin
                    data_mem_resp  = 1'b1;
                    data_mem_rdata = mem_rdata;
                    state_d        = IDLE;
                end
            end
            SERVE_I, DROP_I: begin
                // A flushed fetch keeps the downstream read alive until it completes, then discards it.
                mem_read    = 1'b1;
                mem_mbe     = req_q.mbe;
                mem_address = req_q.addr;
                if (mem_resp) begin
                    state_d = IDLE;
                    if (state_q == SERVE_I && !flush_ip) begin
                        instr_mem_resp  = 1'b1;
                        instr_mem_rdata = mem_rdata;
                    end
                end else if (flush_ip) begin
                    state_d = DROP_I;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= 1'b0;
`else
            starve_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`else
            starve_q     <= starve_d;
`endif
        end
    end

    a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst)
        !(state_q == IDLE && data_read && data_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a transaction-level arbitration model.
module tb_mem_arbiter;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_ip;
    logic        instr_read;
    logic [31:0] instr_mem_address;
    logic        instr_mem_resp;
    logic [31:0] instr_mem_rdata;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_wdata;
    logic        data_mem_resp;
    logic [31:0] data_mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .flush_ip(flush_ip),
        .instr_read(instr_read), .instr_mem_address(instr_mem_address),
        .instr_mem_resp(instr_mem_resp), .instr_mem_rdata(instr_mem_rdata),
        .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
        .data_mem_address(data_mem_address), .data_mem_wdata(data_mem_wdata),
        .data_mem_resp(data_mem_resp), .data_mem_rdata(data_mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_mbe(mem_mbe),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Pending requests as seen by the requesters, and the model's starvation count.
    logic        i_pend, d_pend, d_wr;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_mbe;
    int          starve;
    logic        last_win_d, last_wr;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_mbe;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_waddr();
        logic [31:0] w;
        w = $urandom();
        w[1:0] = 2'b00;
        return w;
    endfunction

    task automatic drive_inputs;
        instr_read        = i_pend;
        instr_mem_address = i_addr;
        data_read         = d_pend && !d_wr;
        data_write        = d_pend && d_wr;
        data_mem_address  = d_addr;
        data_mem_wdata    = d_wdata;
        data_mbe          = d_mbe;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_mem_read"}, mem_read, 1'b0);
        chk1({tag, "_mem_write"}, mem_write, 1'b0);
        chk32({tag, "_mem_address"}, mem_address, 32'h0);
        chk32({tag, "_mem_mbe"}, 32'(mem_mbe), 32'h0);
        chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk1({tag, "_instr_resp"}, instr_mem_resp, 1'b0);
        chk1({tag, "_data_resp"}, data_mem_resp, 1'b0);
    endtask

    // Called in an IDLE cycle; arbitrates the pending requests, serves the winner with the
    // given memory latency, optionally flushing on cycle flush_at (flush_at >= lat means none).
    task automatic run_round(input int lat, input int flush_at, input logic [31:0] rdata,
                             input logic idle_flush);
        logic        win_d, e_rd, e_wr, e_iresp;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_mbe;
        drive_inputs();
        flush_ip  = idle_flush;
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
        #1;
        chk1("idle_mem_read", mem_read, 1'b0);
        chk1("idle_mem_write", mem_write, 1'b0);
        chk1("idle_instr_resp", instr_mem_resp, 1'b0);

        win_d = d_pend && (!i_pend || starve < LIMIT);
        if (!i_pend)     starve = 0;
        else if (win_d)  starve = (starve < LIMIT) ? starve + 1 : LIMIT;
        else             starve = 0;
        if (win_d) begin
            e_addr = d_addr; e_rd = !d_wr; e_wr = d_wr; e_mbe = d_mbe; e_wdata = d_wdata;
        end else begin
            e_addr = i_addr; e_rd = 1'b1; e_wr = 1'b0; e_mbe = 4'hF; e_wdata = 32'h0;
        end
        e_iresp = !win_d && (flush_at >= lat);
        tick;

        for (int c = 0; c < lat; c++) begin
            flush_ip  = (c == flush_at);
            mem_resp  = (c == lat - 1);
            mem_rdata = (c == lat - 1) ? rdata : $urandom();
            if (c >= 1) begin
                if (win_d) data_mem_address = rand_waddr();
                else       instr_mem_address = rand_waddr();
            end
            #1;
            if (c == 0) begin
                last_addr = mem_address; last_wr = mem_write;
                last_mbe = mem_mbe; last_wdata = mem_wdata;
                chk32("grant_mem_mbe", 32'(mem_mbe), 32'(e_mbe));
                if (win_d) chk32("grant_mem_wdata", mem_wdata, e_wdata);
            end
            chk1("serve_mem_read", mem_read, e_rd);
            chk1("serve_mem_write", mem_write, e_wr);
            chk32("serve_mem_address", mem_address, e_addr);
            if (c == lat - 1) begin
                chk1("resp_data", data_mem_resp, win_d);
                chk1("resp_instr", instr_mem_resp, e_iresp);
                if (win_d)   chk32("resp_data_rdata", data_mem_rdata, rdata);
                if (e_iresp) chk32("resp_instr_rdata", instr_mem_rdata, rdata);
            end else begin
                chk1("early_data_resp", data_mem_resp, 1'b0);
                chk1("early_instr_resp", instr_mem_resp, 1'b0);
            end
            tick;
        end

        mem_resp = 1'b0;
        flush_ip = 1'b0;
        if (win_d) d_pend = 1'b0;
        else       i_pend = 1'b0;
        drive_inputs();
        last_win_d = win_d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int loads;
        i_pend = 0; d_pend = 0; d_wr = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_mbe = 0;
        starve = 0;
        rst = 1'b0; flush_ip = 1'b0; mem_resp = 1'b0; mem_rdata = 32'h0;
        instr_read = 1'b1; instr_mem_address = 32'h60;
        data_read = 1'b1; data_write = 1'b0; data_mbe = 4'hF;
        data_mem_address = 32'h2000; data_mem_wdata = 32'h0;
        tick; tick; tick;
        chk_all_zero("reset");
        rst = 1'b1;

        // Fetch only.
        i_pend = 1; i_addr = 32'h60;
        run_round(1, 1, 32'h0000_0013, 1'b0);
        chk32("fetch_addr", last_addr, 32'h60);

        // Simultaneous fetch and load: load first.
        i_pend = 1; i_addr = 32'h100;
        d_pend = 1; d_wr = 0; d_addr = 32'h2000; d_mbe = 4'hF; d_wdata = 32'h0;
        run_round(2, 2, 32'hDEAD_BEEF, 1'b0);
        chk32("order_first", last_addr, 32'h2000);
        run_round(3, 3, 32'h1234_5678, 1'b0);
        chk32("order_second", last_addr, 32'h100);

        // Byte store.
        d_pend = 1; d_wr = 1; d_addr = 32'h2004; d_mbe = 4'b0010; d_wdata = 32'h0000_AB00;
        run_round(2, 2, 32'h0, 1'b0);
        chk1("store_write", last_wr, 1'b1);
        chk32("store_mbe", 32'(last_mbe), 32'h2);
        chk32("store_wdata", last_wdata, 32'h0000_AB00);

        // Fetch held while nine loads arrive back to back.
        i_pend = 1; i_addr = 32'h80; loads = 0;
        for (int k = 0; k < 10; k++) begin
            if (!d_pend && loads < 9) begin
                d_pend = 1; d_wr = 0; d_addr = 32'h3000 + 32'(4 * loads);
                d_mbe = 4'hF; d_wdata = 32'h0; loads++;
            end
            run_round(1, 1, 32'(k), 1'b0);
            chk1("starve_winner", last_win_d, (k != 8));
        end
        chk32("starve_last_load", last_addr, 32'h3020);

        // Flush one cycle into a five-cycle fetch, then a fresh fetch.
        i_pend = 1; i_addr = 32'h40;
        run_round(5, 1, 32'hCAFE_0001, 1'b0);
        i_pend = 1; i_addr = 32'h44;
        run_round(2, 2, 32'hCAFE_0002, 1'b0);
        chk32("post_flush_addr", last_addr, 32'h44);

        // Reset in the middle of a load.
        d_pend = 1; d_wr = 0; d_addr = 32'h2100; d_mbe = 4'hF; d_wdata = 32'h0;
        drive_inputs();
        #1;
        tick;
        chk1("pre_reset_read", mem_read, 1'b1);
        rst = 1'b0;
        tick;
        chk_all_zero("midreset");
        rst = 1'b1;
        starve = 0;
        run_round(2, 2, 32'h5555_AAAA, 1'b0);
        chk32("post_reset_addr", last_addr, 32'h2100);

        // Randomized traffic.
        for (int r = 0; r < 60; r++) begin
            int lat, fa;
            if (!i_pend && ($urandom() % 2 == 0)) begin
                i_pend = 1; i_addr = rand_waddr();
            end
            if (!d_pend && ($urandom() % 3 != 0)) begin
                d_pend = 1; d_wr = 1'($urandom() % 2); d_addr = rand_waddr();
                d_mbe = 4'($urandom_range(1, 15)); d_wdata = $urandom();
            end
            if (!i_pend && !d_pend) begin
                i_pend = 1; i_addr = rand_waddr();
            end
            lat = $urandom_range(1, 4);
            fa  = ($urandom() % 3 == 0) ? $urandom_range(0, lat - 1) : lat;
            run_round(lat, fa, $urandom(), 1'($urandom() % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
